// File: rtl/saradc_dig_startup_seq.sv
// SAR ADC digital startup sequencer.
// Steps the analog front end through enable, LDO release, offset-settle (OCS) window,
// FSM enable and startup calibration with timeout/retry, then holds in RUN or ERROR.
// Dropping mod_enable_i runs a timed shutdown back to IDLE.
module saradc_dig_startup_seq #(
  parameter int CNT_W       = 8,
  parameter int ENABLE_DEL  = 4,
  parameter int REL_LDO_DEL = 8,
  parameter int OCS_PULSES  = 8,
  parameter int SUCAL_DEL   = 20,
  parameter int SUCAL_TMO   = 100,
  parameter int N_RETRY     = 2,
  parameter int OFF_DEL     = 4,
  parameter int LOWSUP_EN   = 1
) (
  input  logic clk,
  input  logic res,
  input  logic mod_enable_i,
  input  logic mod_lowsup_i,
  input  logic dscal_i,
  input  logic sucal_done_i,
  output logic mod_ready_o,
  output logic error_o,
  output logic enable_o,
  output logic release_ldo_o,
  output logic lowsup_o,
  output logic cp_clk_ldo_enable_o,
  output logic scab_clk_enable_o,
  output logic su_ocs_high_o,
  output logic enable_fsms_o,
  output logic sucal_o,
  output logic enable_conv_o,
  output logic [(N_RETRY > 0 ? $clog2(N_RETRY+1) : 1)-1:0] retry_cnt_o
);

  localparam int RW      = (N_RETRY > 0) ? $clog2(N_RETRY+1) : 1;
  localparam int OCS_DEL = 2*OCS_PULSES - 1;
  localparam int CNT_MAX = (2**CNT_W) - 1;

  localparam logic [CNT_W-1:0] L_EN   = CNT_W'(ENABLE_DEL);
  localparam logic [CNT_W-1:0] L_LDO  = CNT_W'(REL_LDO_DEL);
  localparam logic [CNT_W-1:0] L_OCS  = CNT_W'(OCS_DEL);
  localparam logic [CNT_W-1:0] L_SDEL = CNT_W'(SUCAL_DEL);
  localparam logic [CNT_W-1:0] L_TMO  = CNT_W'(SUCAL_TMO);
  localparam logic [CNT_W-1:0] L_OFF  = CNT_W'(OFF_DEL);
  localparam logic [RW-1:0]    RETRY_MAX = RW'(N_RETRY);
  localparam logic             LS_EN  = (LOWSUP_EN != 0);

  // Reject delays that would not fit in the shared down-counter.
  if (ENABLE_DEL > CNT_MAX || REL_LDO_DEL > CNT_MAX || OCS_DEL > CNT_MAX ||
      SUCAL_DEL > CNT_MAX || SUCAL_TMO > CNT_MAX || OFF_DEL > CNT_MAX) begin : g_del_chk
    $error("saradc_dig_startup_seq: a delay parameter exceeds 2**CNT_W-1");
  end
  if (OCS_PULSES < 1) begin : g_ocs_chk
    $error("saradc_dig_startup_seq: OCS_PULSES must be at least 1");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_ENABLE, S_REL_LDO, S_WAIT_OCS, S_WAIT_SUCAL,
    S_PRE_SUCAL, S_SUCAL, S_RUN, S_ERROR, S_SHUTDOWN
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic enable_q, enable_d, rel_q, rel_d, ls_q, ls_d, cp_q, cp_d, scab_q, scab_d;
  logic ocs_q, ocs_d, fsms_q, fsms_d, sucal_q, sucal_d, conv_q, conv_d;
  logic ready_q, ready_d, err_q, err_d;

  // Next-state and next-output logic; everything holds unless a transition changes it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
    retry_d  = retry_q;
    enable_d = enable_q;
    rel_d    = rel_q;
    ls_d     = ls_q;
    cp_d     = cp_q;
    scab_d   = scab_q;
    ocs_d    = ocs_q;
    fsms_d   = fsms_q;
    sucal_d  = sucal_q;
    conv_d   = conv_q;
    ready_d  = ready_q;
    err_d    = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (mod_enable_i) begin
          enable_d = 1'b1;
          scab_d   = 1'b1;
          ls_d     = mod_lowsup_i & LS_EN;
          cp_d     = mod_lowsup_i & LS_EN;
          cnt_d    = L_EN;
          state_d  = S_ENABLE;
        end
      end
      S_ENABLE: begin
        if (cnt_q == '0) begin
          rel_d   = 1'b1;
          cnt_d   = L_LDO;
          state_d = S_REL_LDO;
        end
      end
      S_REL_LDO: begin
        if (cnt_q == '0) begin
          ocs_d   = 1'b1;
          cnt_d   = L_OCS;
          state_d = S_WAIT_OCS;
        end
      end
      S_WAIT_OCS: begin
        if (cnt_q == '0) begin
          ocs_d   = 1'b0;
          cnt_d   = L_SDEL;
          state_d = S_WAIT_SUCAL;
        end
      end
      S_WAIT_SUCAL: begin
        if (cnt_q == '0) begin
          fsms_d  = 1'b1;
          state_d = S_PRE_SUCAL;
        end
      end
      S_PRE_SUCAL: begin
        sucal_d = !dscal_i;
        cnt_d   = L_TMO;
        state_d = S_SUCAL;
      end
      S_SUCAL: begin
        sucal_d = 1'b0;
        // Done (or bypass) takes priority over a coincident timeout.
        if (sucal_done_i || dscal_i) begin
          ready_d = 1'b1;
          conv_d  = 1'b1;
          state_d = S_RUN;
        end else if (cnt_q == '0 && SUCAL_TMO != 0) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RW'(1);
            state_d = S_PRE_SUCAL;
          end else begin
            err_d   = 1'b1;
            state_d = S_ERROR;
          end
        end
      end
      S_RUN, S_ERROR: ;
      S_SHUTDOWN: begin
        if (cnt_q == '0) begin
          enable_d = 1'b0;
          rel_d    = 1'b0;
          ls_d     = 1'b0;
          cp_d     = 1'b0;
          scab_d   = 1'b0;
          ocs_d    = 1'b0;
          fsms_d   = 1'b0;
          sucal_d  = 1'b0;
          conv_d   = 1'b0;
          ready_d  = 1'b0;
          err_d    = 1'b0;
          retry_d  = '0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Enable withdrawn mid-sequence: stop digital activity, keep analog supplies up for OFF_DEL.
    if (!mod_enable_i && state_q != S_IDLE && state_q != S_SHUTDOWN) begin
      ready_d = 1'b0;
      conv_d  = 1'b0;
      fsms_d  = 1'b0;
      sucal_d = 1'b0;
      ocs_d   = 1'b0;
      err_d   = 1'b0;
      cnt_d   = L_OFF;
      state_d = S_SHUTDOWN;
    end
  end

  // State, counter and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      retry_q  <= '0;
      enable_q <= 1'b0;
      rel_q    <= 1'b0;
      ls_q     <= 1'b0;
      cp_q     <= 1'b0;
      scab_q   <= 1'b0;
      ocs_q    <= 1'b0;
      fsms_q   <= 1'b0;
      sucal_q  <= 1'b0;
      conv_q   <= 1'b0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      enable_q <= enable_d;
      rel_q    <= rel_d;
      ls_q     <= ls_d;
      cp_q     <= cp_d;
      scab_q   <= scab_d;
      ocs_q    <= ocs_d;
      fsms_q   <= fsms_d;
      sucal_q  <= sucal_d;
      conv_q   <= conv_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

  assign mod_ready_o         = ready_q;
  assign error_o             = err_q;
  assign enable_o            = enable_q;
  assign release_ldo_o       = rel_q;
  assign lowsup_o            = ls_q;
  assign cp_clk_ldo_enable_o = cp_q;
  assign scab_clk_enable_o   = scab_q;
  assign su_ocs_high_o       = ocs_q;
  assign enable_fsms_o       = fsms_q;
  assign sucal_o             = sucal_q;
  assign enable_conv_o       = conv_q;
  assign retry_cnt_o         = retry_q;

endmodule
